// File: rtl/int_arbiter.sv
// Interrupt arbiter: edge/level capture, enable mask, fixed-priority
// single-outstanding grant with IDLE/REQ/SERVICE handshake to the core.
module int_arbiter #(
    parameter int                 NUM_SRC   = 4,
    parameter int                 ID_W      = 2,
    parameter logic [NUM_SRC-1:0] EDGE_MODE = {NUM_SRC{1'b1}},
    parameter logic [NUM_SRC-1:0] MASK_RST  = {NUM_SRC{1'b1}}
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_SRC-1:0] irq_src,
    input  logic               mask_wr,
    input  logic [NUM_SRC-1:0] mask_data,
    input  logic               irq_ack,
    input  logic               irq_eoi,
    output logic               interrupter,
    output logic [ID_W-1:0]    irq_id,
    output logic [NUM_SRC-1:0] pending,
    output logic               in_service
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_REQ     = 2'd1;
    localparam logic [1:0] S_SERVICE = 2'd2;

    logic [1:0]         state;
    logic [NUM_SRC-1:0] mask;
    logic [NUM_SRC-1:0] armed;
    logic [NUM_SRC-1:0] elig;
    logic [NUM_SRC-1:0] set_edge;
    logic [NUM_SRC-1:0] ack_clr;
    logic [NUM_SRC-1:0] pending_nxt;
    logic [ID_W-1:0]    low_id;
    logic               ack_take;

    assign ack_take = (state == S_REQ) && irq_ack;
    assign elig     = pending & mask;
    // armed = channel sampled low since reset, so a source held high
    // through reset needs a fresh low-to-high transition
    assign set_edge = irq_src & armed;

    always_comb begin
        ack_clr = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            ack_clr[i] = ack_take && (irq_id == ID_W'(i));
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_SRC; i++) begin
            if (EDGE_MODE[i]) begin
                pending_nxt[i] = set_edge[i] | (pending[i] & ~ack_clr[i]);
            end else begin
                pending_nxt[i] = irq_src[i];
            end
        end
    end

    always_comb begin
        low_id = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (elig[i]) begin
                low_id = ID_W'(i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            interrupter <= 1'b0;
            irq_id      <= '0;
            in_service  <= 1'b0;
            pending     <= '0;
            mask        <= MASK_RST;
            armed       <= '0;
        end else begin
            pending <= pending_nxt;
            armed   <= ~irq_src;
            if (mask_wr) begin
                mask <= mask_data;
            end
            unique case (1'b1)
                (state == S_IDLE): begin
                    if (|elig) begin
                        irq_id      <= low_id;
                        interrupter <= 1'b1;
                        state       <= S_REQ;
                    end
                end
                (state == S_REQ): begin
                    if (irq_ack) begin
                        interrupter <= 1'b0;
                        in_service  <= 1'b1;
                        state       <= S_SERVICE;
                    end
                end
                (state == S_SERVICE): begin
                    if (irq_eoi) begin
                        in_service <= 1'b0;
                        state      <= S_IDLE;
                    end
                end
                default: begin
                    interrupter <= 1'b0;
                    in_service  <= 1'b0;
                    state       <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_int_arbiter.sv
// Bench for int_arbiter: all-edge and mixed edge/level instances share
// stimulus; a behavioural model is compared every cycle.
module tb_int_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] irq_src;
    logic       mask_wr;
    logic [3:0] mask_data;
    logic       irq_ack;
    logic       irq_eoi;

    logic       intr0, intr1;
    logic [1:0] id0, id1;
    logic [3:0] pend0, pend1;
    logic       svc0, svc1;

    int errors = 0;
    int checks = 0;

    logic [3:0] m_pend [2];
    logic [3:0] m_mask [2];
    logic [3:0] m_low  [2];
    int         m_phase[2];
    int         m_id   [2];

    always #5 clk = ~clk;

    int_arbiter dut0 (
        .clk(clk), .rst(rst), .irq_src(irq_src),
        .mask_wr(mask_wr), .mask_data(mask_data),
        .irq_ack(irq_ack), .irq_eoi(irq_eoi),
        .interrupter(intr0), .irq_id(id0),
        .pending(pend0), .in_service(svc0)
    );

    int_arbiter #(
        .NUM_SRC(4), .ID_W(2),
        .EDGE_MODE(4'b1101), .MASK_RST(4'b1111)
    ) dut1 (
        .clk(clk), .rst(rst), .irq_src(irq_src),
        .mask_wr(mask_wr), .mask_data(mask_data),
        .irq_ack(irq_ack), .irq_eoi(irq_eoi),
        .interrupter(intr1), .irq_id(id1),
        .pending(pend1), .in_service(svc1)
    );

    function automatic logic [3:0] em(int k);
        return (k == 0) ? 4'b1111 : 4'b1101;
    endfunction

    task automatic chk(string nm, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // phase: 0 idle, 1 requesting, 2 in service
    task automatic model_step();
        for (int k = 0; k < 2; k++) begin
            logic [3:0] np;
            logic [3:0] el;
            if (rst) begin
                m_pend[k]  = 4'b0000;
                m_mask[k]  = 4'b1111;
                m_low[k]   = 4'b0000;
                m_phase[k] = 0;
                m_id[k]    = 0;
            end else begin
                el = m_pend[k] & m_mask[k];
                np = m_pend[k];
                for (int i = 0; i < 4; i++) begin
                    if (!em(k)[i]) np[i] = irq_src[i];
                    else if (irq_src[i] && m_low[k][i]) np[i] = 1'b1;
                    else if (m_phase[k] == 1 && irq_ack && m_id[k] == i)
                        np[i] = 1'b0;
                end
                if (m_phase[k] == 0) begin
                    if (el != 4'b0000) begin
                        for (int i = 3; i >= 0; i--)
                            if (el[i]) m_id[k] = i;
                        m_phase[k] = 1;
                    end
                end else if (m_phase[k] == 1) begin
                    if (irq_ack) m_phase[k] = 2;
                end else begin
                    if (irq_eoi) m_phase[k] = 0;
                end
                m_pend[k] = np;
                m_low[k]  = ~irq_src;
                if (mask_wr) m_mask[k] = mask_data;
            end
        end
    endtask

    task automatic compare_model();
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("m%0d_intr", k),
                (k == 0) ? int'(intr0) : int'(intr1),
                (m_phase[k] == 1) ? 1 : 0);
            chk($sformatf("m%0d_svc", k),
                (k == 0) ? int'(svc0) : int'(svc1),
                (m_phase[k] == 2) ? 1 : 0);
            chk($sformatf("m%0d_id", k),
                (k == 0) ? int'(id0) : int'(id1), m_id[k]);
            chk($sformatf("m%0d_pend", k),
                (k == 0) ? int'(pend0) : int'(pend1), int'(m_pend[k]));
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        #1;
        compare_model();
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; irq_src = 4'b0000; mask_wr = 1'b0;
        mask_data = 4'b0000; irq_ack = 1'b0; irq_eoi = 1'b0;
        step(); step();
        chk("rst_intr", int'(intr0), 0);
        chk("rst_pend", int'(pend0), 0);
        chk("rst_svc", int'(svc0), 0);
        chk("rst_id", int'(id0), 0);
        rst = 1'b0; step();

        // single edge source
        irq_src = 4'b0100; step();
        chk("s2_pend", int'(pend0), 4'b0100);
        chk("s2_nointr", int'(intr0), 0);
        step();
        chk("s2_intr", int'(intr0), 1);
        chk("s2_id", int'(id0), 2);
        irq_ack = 1'b1; step();
        chk("s2_ackpend", int'(pend0), 0);
        chk("s2_svc", int'(svc0), 1);
        chk("s2_ackintr", int'(intr0), 0);
        irq_ack = 1'b0; irq_src = 4'b0000; irq_eoi = 1'b1; step();
        irq_eoi = 1'b0; step();

        // simultaneous sources, priority and idle gap
        irq_src = 4'b1010; step();
        chk("p_pend", int'(pend0), 4'b1010);
        step();
        chk("p_intr1", int'(intr0), 1);
        chk("p_id1", int'(id0), 1);
        irq_ack = 1'b1; step();
        irq_ack = 1'b0; irq_src = 4'b0000; irq_eoi = 1'b1; step();
        chk("p_gap", int'(intr0), 0);
        chk("p_gapsvc", int'(svc0), 0);
        irq_eoi = 1'b0; step();
        chk("p_intr3", int'(intr0), 1);
        chk("p_id3", int'(id0), 3);
        irq_ack = 1'b1; step();
        irq_ack = 1'b0; irq_eoi = 1'b1; step();
        irq_eoi = 1'b0; step();

        // masking
        mask_wr = 1'b1; mask_data = 4'b1110; step();
        mask_wr = 1'b0; irq_src = 4'b0001; step();
        chk("m_pend", int'(pend0), 4'b0001);
        step();
        chk("m_hold1", int'(intr0), 0);
        step();
        chk("m_hold2", int'(intr0), 0);
        mask_wr = 1'b1; mask_data = 4'b1111; step();
        chk("m_wredge", int'(intr0), 0);
        mask_wr = 1'b0; step();
        chk("m_intr", int'(intr0), 1);
        chk("m_id", int'(id0), 0);
        irq_ack = 1'b1; irq_src = 4'b0000; step();
        irq_ack = 1'b0; irq_eoi = 1'b1; step();
        irq_eoi = 1'b0; step();

        // re-rise coincident with ack
        irq_src = 4'b0001; step(); step();
        chk("rr_intr", int'(intr0), 1);
        irq_src = 4'b0000; step();
        irq_src = 4'b0001; irq_ack = 1'b1; step();
        chk("rr_pend", int'(pend0), 4'b0001);
        chk("rr_svc", int'(svc0), 1);
        irq_ack = 1'b0; irq_eoi = 1'b1; step();
        irq_eoi = 1'b0; step();
        chk("rr_regrant", int'(intr0), 1);
        chk("rr_id", int'(id0), 0);
        irq_ack = 1'b1; step();
        chk("rr_clr", int'(pend0), 0);
        irq_ack = 1'b0; irq_src = 4'b0000; irq_eoi = 1'b1; step();
        irq_eoi = 1'b0; step();

        // level channel 1 on dut1 held through ack and eoi
        irq_src = 4'b0010; step(); step();
        chk("lv_intr", int'(intr1), 1);
        chk("lv_id", int'(id1), 1);
        irq_ack = 1'b1; step();
        chk("lv_pend", int'(pend1), 4'b0010);
        chk("lv_edgeclr", int'(pend0), 0);
        irq_ack = 1'b0; irq_eoi = 1'b1; step();
        irq_eoi = 1'b0; step();
        chk("lv_regrant", int'(intr1), 1);
        chk("lv_reid", int'(id1), 1);
        chk("lv_edge_idle", int'(intr0), 0);
        irq_ack = 1'b1; step();
        chk("lv_ignack", int'(svc0), 0);
        irq_ack = 1'b0; irq_src = 4'b0000; irq_eoi = 1'b1; step();
        irq_eoi = 1'b0; step();

        // ack and eoi together in REQ
        irq_src = 4'b0100; step(); step();
        chk("ae_intr", int'(intr0), 1);
        irq_ack = 1'b1; irq_eoi = 1'b1; step();
        chk("ae_svc", int'(svc0), 1);
        chk("ae_intr0", int'(intr0), 0);
        irq_ack = 1'b0; irq_eoi = 1'b0; step();
        chk("ae_stay", int'(svc0), 1);
        irq_eoi = 1'b1; irq_src = 4'b0000; step();
        chk("ae_done", int'(svc0), 0);
        irq_eoi = 1'b0; step();

        // reset mid-REQ with source held high through it
        mask_wr = 1'b1; mask_data = 4'b0111; step();
        mask_wr = 1'b0; irq_src = 4'b0001; step(); step();
        chk("rq_intr", int'(intr0), 1);
        rst = 1'b1; step();
        chk("rq_rintr", int'(intr0), 0);
        chk("rq_rpend", int'(pend0), 0);
        chk("rq_rsvc", int'(svc0), 0);
        chk("rq_rid", int'(id0), 0);
        rst = 1'b0; step(); step();
        chk("rq_noedge", int'(pend0), 0);
        chk("rq_nointr", int'(intr0), 0);
        irq_src = 4'b1001; step();
        chk("rq_pend3", int'(pend0), 4'b1000);
        step();
        chk("rq_mask", int'(intr0), 1);
        chk("rq_id3", int'(id0), 3);
        irq_ack = 1'b1; step();
        irq_ack = 1'b0; irq_src = 4'b0000; irq_eoi = 1'b1; step();
        irq_eoi = 1'b0; step();

        // random traffic against the model
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 3) == 0) irq_src = 4'($urandom);
            irq_ack   = ($urandom_range(0, 3) == 0);
            irq_eoi   = ($urandom_range(0, 3) == 0);
            mask_wr   = ($urandom_range(0, 19) == 0);
            mask_data = 4'($urandom);
            rst       = ($urandom_range(0, 99) == 0);
            step();
        end
        rst = 1'b0; irq_ack = 1'b0; irq_eoi = 1'b0; mask_wr = 1'b0;
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/int_arbiter.md
INT_ARBITER -- requirements
Module: int_arbiter

Interface
REQ-001 Parameter NUM_SRC, default 4: number of interrupt source channels, range 1..32.
REQ-002 Parameter ID_W, default 2: width of irq_id; SHALL equal max(1, ceil(log2(NUM_SRC))).
REQ-003 Parameter EDGE_MODE, default {NUM_SRC{1'b1}}: per channel, 1 = rising-edge triggered, 0 = level triggered.
REQ-004 Parameter MASK_RST, default {NUM_SRC{1'b1}}: reset value of the enable mask.
REQ-005 clk  input  1  system clock; all state updates on its rising edge.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 irq_src  input  NUM_SRC  raw interrupt sources, synchronous to clk.
REQ-008 mask_wr  input  1  load mask_data into the enable mask this cycle.
REQ-009 mask_data  input  NUM_SRC  new enable mask (1 = enabled).
REQ-010 irq_ack  input  1  core has taken the trap for the current irq_id.
REQ-011 irq_eoi  input  1  core has finished the handler (mret).
REQ-012 interrupter  output  1  registered interrupt request to RV32core.
REQ-013 irq_id  output  ID_W  index of the granted channel; valid while interrupter=1 or FSM in SERVICE.
REQ-014 pending  output  NUM_SRC  current pending register.
REQ-015 in_service  output  1  high while FSM is in SERVICE.

Function
REQ-016 Edge channel: the pending bit SHALL set on the first cycle irq_src=1 when the previous sample was 0; it SHALL clear on irq_ack when that channel is the granted id.
REQ-017 When an edge-channel set and its ack-clear occur in the same cycle, set SHALL win.
REQ-018 Level channel: the pending bit SHALL equal irq_src registered one cycle earlier; it is not cleared by ack.
REQ-019 Masked channels SHALL still update pending but SHALL NOT be granted.
REQ-020 mask_wr SHALL update the mask at the clock edge; the new mask applies to arbitration from the next cycle.
REQ-021 FSM states: IDLE, REQ, SERVICE.
REQ-022 IDLE: if (pending & mask) != 0, latch irq_id = lowest set index, assert interrupter, go to REQ; otherwise stay.
REQ-023 REQ: hold interrupter=1 and irq_id constant until irq_ack=1; on ack deassert interrupter next cycle, go to SERVICE.
REQ-024 The granted request SHALL NOT be withdrawn in REQ, even if the source drops or is masked (spurious grant permitted).
REQ-025 SERVICE: in_service=1; on irq_eoi=1 go to IDLE; no new grant while in SERVICE (no nesting).
REQ-026 irq_ack outside REQ and irq_eoi outside SERVICE SHALL be ignored.
REQ-027 irq_ack and irq_eoi asserted together in REQ: ack SHALL be taken, eoi ignored; the FSM enters SERVICE.
REQ-028 Latency: edge source sampled high at edge k (prior 0) -> pending bit 1 after edge k -> interrupter=1 after edge k+1.
REQ-029 From IDLE with eligible pending, a new grant SHALL occur on the first edge after eoi returns the FSM to IDLE (one idle cycle minimum between grants).
REQ-030 interrupter, irq_id and in_service SHALL be driven directly from registers.

Reset
REQ-031 On rst=1 at a clock edge: FSM=IDLE, interrupter=0, irq_id=0, in_service=0, pending=0, mask=MASK_RST, edge history=0.
REQ-032 Reset SHALL override all other inputs in the same cycle, including mid-REQ or mid-SERVICE; a source held high through reset SHALL NOT produce an edge until it falls and rises again.

Verification
REQ-033 NUM_SRC=4, source 2 rises after reset -> pending=4'b0100 one cycle later, interrupter=1 and irq_id=2 the next cycle; ack -> pending=0, in_service=1.
REQ-034 Sources 1 and 3 rise together -> irq_id=1 first; after ack+eoi -> irq_id=3 granted, with one IDLE cycle between the grants.
REQ-035 Mask written to 4'b1110, source 0 rises -> pending bit0=1, interrupter stays 0; mask written to 4'b1111 -> grant irq_id=0.
REQ-036 Level channel (EDGE_MODE bit1=0) held high through ack and eoi -> re-granted with irq_id=1 after the eoi.
REQ-037 rst asserted while in REQ with interrupter=1 -> next cycle interrupter=0, pending=0, in_service=0, mask=MASK_RST.
REQ-038 Source 0 re-rises in the same cycle as its ack -> pending bit0 stays 1; grant irq_id=0 again after eoi.
